uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 9600, serial baud rate.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 uart_rxd  input  1  serial receive line, asynchronous to clk, idle high.
REQ-006 uart_rx_data  output  8  last correctly framed received byte.
REQ-007 uart_rx_done  output  1  one-cycle pulse; uart_rx_data newly valid.
REQ-008 uart_rx_busy  output  1  high while a frame is being received.
REQ-009 uart_frame_err  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 BAUD_CNT_MAX SHALL equal CLK_FREQ/UART_BPS (integer division; 5208 at defaults); HALF_CNT SHALL equal BAUD_CNT_MAX/2.
REQ-012 uart_rxd SHALL pass a 2-flop synchronizer; all decisions use the synchronized signal rxd_s plus one extra delay flop for edge detection.
REQ-013 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: falling edge on rxd_s -> START, baud_cnt cleared to 0.
REQ-015 baud_cnt (16 bit) SHALL count 0..BAUD_CNT_MAX-1 and wrap to 0 while in START, DATA, STOP; held at 0 in IDLE and WAIT_HIGH.
REQ-016 START: at baud_cnt == HALF_CNT-1 sample rxd_s; if 1 (glitch) -> IDLE without any output pulse; if 0 -> continue, and at baud_cnt == BAUD_CNT_MAX-1 -> DATA, bit_cnt = 0.
REQ-017 DATA: at baud_cnt == HALF_CNT-1 shift rxd_s into shift register position bit_cnt; at baud_cnt == BAUD_CNT_MAX-1 increment bit_cnt (3 bit); after bit 7 period -> STOP.
REQ-018 STOP: at baud_cnt == HALF_CNT-1 sample rxd_s; if 1: uart_rx_data <= shift register, uart_rx_done pulses next cycle, -> IDLE immediately (no wait for full stop period).
REQ-019 STOP sample 0: uart_frame_err pulses one cycle, uart_rx_data unchanged, uart_rx_done stays low, -> WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until rxd_s == 1, then -> IDLE; a held-low line (break) SHALL NOT start new frames.
REQ-021 uart_rx_busy SHALL be 1 in START, DATA, STOP, WAIT_HIGH, 0 in IDLE; registered output.
REQ-022 uart_rx_done and uart_frame_err SHALL never be high in the same cycle and SHALL be exactly one clk wide.
REQ-023 Back-to-back frames (next start bit directly after stop bit) SHALL be received without loss.
REQ-024 uart_rx_data SHALL hold its value until the next correctly framed byte.

Reset
REQ-025 Reset SHALL force: state IDLE, synchronizer and edge flops to 1, baud_cnt 0, bit_cnt 0, shift register 0, uart_rx_data 8'h00, uart_rx_done 0, uart_rx_busy 0, uart_frame_err 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done/err pulse; reception resumes at the next falling edge after release.

Structure
REQ-027 CLK_FREQ/UART_BPS defaults and BAUD_CNT_MAX derivation SHALL live in the shared uart constants package, common with the transmitter.
REQ-028 The 2-flop synchronizer SHALL be a sub-module named sync_2ff (1-bit, reset value parameterized, here 1).
REQ-029 FSM, counters and shift register SHALL stay in uart_rx; no further sub-modules.

Verification
REQ-030 Byte 8'h55 at 9600 baud, defaults -> uart_rx_done pulse once, uart_rx_data == 8'h55, uart_frame_err never high.
REQ-031 Bytes 8'hA3, 8'h00, 8'hFF back-to-back, no idle gap -> three done pulses, data A3, 00, FF in order.
REQ-032 1000-clk low glitch on idle line -> no done, no err, busy high less than HALF_CNT+4 clks, returns IDLE.
REQ-033 Frame 8'h3C with stop bit forced 0, line then held low 20 bit times -> one uart_frame_err pulse, uart_rx_data unchanged, no new frame until line high, then next byte 8'h81 received correctly.
REQ-034 rst_n asserted during data bit 4 of 8'hC5, released, then 8'h5A sent -> no pulse for C5, uart_rx_data == 8'h5A after done.
REQ-035 Transmitter baud rate offset +/-2% -> 8'h69 still received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants shared by the UART transmitter and receiver: default clock/baud
// figures, the baud divider derivation and the receiver state encoding.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF = 50_000_000;
  localparam int unsigned UART_BPS_DEF = 9600;

  // Clocks per bit period; integer division, 5208 at the defaults.
  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned bps);
    return clk_freq / bps;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1: mid-bit sampling, stop-bit framing check and a
// break guard that blocks new frames until the line returns high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
  parameter int unsigned UART_BPS = UART_BPS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_busy,
  output logic       uart_frame_err
);

  localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int unsigned HALF_CNT     = BAUD_CNT_MAX / 2;
  localparam logic [15:0] CNT_LAST     = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] CNT_MID      = 16'(HALF_CNT - 1);

  logic        rxd_s;
  logic        rxd_d;
  logic        rxd_fall;
  rx_state_t   state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (uart_rxd),
    .q    (rxd_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_d <= 1'b1;
    end else begin
      rxd_d <= rxd_s;
    end
  end

  assign rxd_fall = rxd_d & ~rxd_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      baud_cnt       <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      uart_rx_data   <= '0;
      uart_rx_done   <= 1'b0;
      uart_rx_busy   <= 1'b0;
      uart_frame_err <= 1'b0;
    end else begin
      uart_rx_done   <= 1'b0;
      uart_frame_err <= 1'b0;

      if (state inside {START, DATA, STOP}) begin
        baud_cnt <= (baud_cnt == CNT_LAST) ? '0 : baud_cnt + 16'd1;
      end else begin
        baud_cnt <= '0;
      end

      case (state)
        IDLE: begin
          uart_rx_busy <= 1'b0;
          if (rxd_fall) begin
            state        <= START;
            baud_cnt     <= '0;
            uart_rx_busy <= 1'b1;
          end
        end

        START: begin
          // A start bit that is high again at mid-bit was noise.
          if (baud_cnt == CNT_MID && rxd_s) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            uart_rx_busy <= 1'b0;
          end else if (baud_cnt == CNT_LAST) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end

        DATA: begin
          if (baud_cnt == CNT_MID) begin
            shift_reg[bit_cnt] <= rxd_s;
          end
          if (baud_cnt == CNT_LAST) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (baud_cnt == CNT_MID) begin
            baud_cnt <= '0;
            if (rxd_s) begin
              uart_rx_data <= shift_reg;
              uart_rx_done <= 1'b1;
              uart_rx_busy <= 1'b0;
              state        <= IDLE;
            end else begin
              uart_frame_err <= 1'b1;
              state          <= WAIT_HIGH;
            end
          end
        end

        WAIT_HIGH: begin
          if (rxd_s) begin
            state        <= IDLE;
            uart_rx_busy <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          uart_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random bytes at
// jittered baud rates, compared against a byte-level reference model.
`timescale 1ns / 1ps
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 3_200_000;
  localparam int unsigned UART_BPS = 100_000;
  localparam int unsigned BIT_CLKS = CLK_FREQ / UART_BPS;
  localparam int unsigned HALF     = BIT_CLKS / 2;
  localparam real         BIT_NS   = 10.0 * BIT_CLKS;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_rx_data;
  logic       uart_rx_done;
  logic       uart_rx_busy;
  logic       uart_frame_err;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rxd      (uart_rxd),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_done  (uart_rx_done),
    .uart_rx_busy  (uart_rx_busy),
    .uart_frame_err(uart_frame_err)
  );

  // Observed events
  logic [7:0] got_q[$];
  int         err_seen  = 0;
  int         both_seen = 0;
  int         wide_seen = 0;
  logic       prev_done = 1'b0;
  logic       prev_err  = 1'b0;

  always @(negedge clk) begin
    if (uart_rx_done) got_q.push_back(uart_rx_data);
    if (uart_frame_err) err_seen++;
    if (uart_rx_done && uart_frame_err) both_seen++;
    if ((uart_rx_done && prev_done) || (uart_frame_err && prev_err)) wide_seen++;
    prev_done <= uart_rx_done;
    prev_err  <= uart_frame_err;
  end

  // Reference model: what a correct receiver must have reported so far
  logic [7:0] exp_q[$];
  int         exp_err  = 0;
  logic [7:0] exp_last = 8'h00;
  int         rd_idx   = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic verify(input string tag);
    check({tag, "_done_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = rd_idx; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    rd_idx = got_q.size();
    check({tag, "_err_count"}, 32'(err_seen), 32'(exp_err));
    check({tag, "_data_reg"}, 32'(uart_rx_data), 32'(exp_last));
    check({tag, "_done_err_overlap"}, 32'(both_seen), 32'd0);
    check({tag, "_pulse_width"}, 32'(wide_seen), 32'd0);
  endtask

  task automatic drive_bit(input logic v, input real f);
    uart_rxd = v;
    #(BIT_NS * f);
  endtask

  // Line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input real f, input logic stop_bit);
    drive_bit(1'b0, f);
    for (int i = 0; i < 8; i++) drive_bit(b[i], f);
    drive_bit(stop_bit, f);
    if (stop_bit) begin
      exp_q.push_back(b);
      exp_last = b;
    end else begin
      exp_err++;
    end
  endtask

  initial begin
    int   busy_cycles;
    logic [7:0] rb;
    real  f;
    logic [7:0] c5;

    // Reset state
    #23;
    check("rst_data", 32'(uart_rx_data), 32'h00);
    check("rst_done", 32'(uart_rx_done), 32'd0);
    check("rst_busy", 32'(uart_rx_busy), 32'd0);
    check("rst_err", 32'(uart_frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #(BIT_NS * 2);

    // Single byte
    send_frame(8'h55, 1.0, 1'b1);
    #(BIT_NS * 2);
    verify("byte55");

    // Back-to-back bytes
    send_frame(8'hA3, 1.0, 1'b1);
    send_frame(8'h00, 1.0, 1'b1);
    send_frame(8'hFF, 1.0, 1'b1);
    #(BIT_NS * 2);
    verify("b2b");

    // Short low glitch on idle line
    busy_cycles = 0;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      if (i == 0) uart_rxd = 1'b0;
      if (i == 10) uart_rxd = 1'b1;
      @(negedge clk);
      if (uart_rx_busy) busy_cycles++;
    end
    check("glitch_busy_seen", 32'(busy_cycles > 0), 32'd1);
    check("glitch_busy_short", 32'(busy_cycles < int'(HALF + 4)), 32'd1);
    check("glitch_idle", 32'(uart_rx_busy), 32'd0);
    verify("glitch");

    // Framing error followed by a break
    send_frame(8'h3C, 1.0, 1'b0);
    #(BIT_NS * 19);
    check("break_busy", 32'(uart_rx_busy), 32'd1);
    verify("ferr");
    uart_rxd = 1'b1;
    #(BIT_NS * 2);
    check("break_release_idle", 32'(uart_rx_busy), 32'd0);
    send_frame(8'h81, 1.0, 1'b1);
    #(BIT_NS * 2);
    verify("after_break");

    // Reset during data bit 4
    c5 = 8'hC5;
    drive_bit(1'b0, 1.0);
    for (int i = 0; i < 4; i++) drive_bit(c5[i], 1.0);
    uart_rxd = c5[4];
    #(BIT_NS / 2);
    @(negedge clk);
    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    exp_last = 8'h00;
    repeat (4) @(negedge clk);
    check("midrst_busy", 32'(uart_rx_busy), 32'd0);
    check("midrst_data", 32'(uart_rx_data), 32'h00);
    rst_n = 1'b1;
    #(BIT_NS * 12);
    verify("midrst");
    send_frame(8'h5A, 1.0, 1'b1);
    #(BIT_NS * 2);
    verify("after_rst");

    // Baud offset tolerance
    send_frame(8'h69, 1.02, 1'b1);
    #(BIT_NS * 2);
    verify("slow2pct");
    send_frame(8'h69, 0.98, 1'b1);
    send_frame(8'h96, 0.98, 1'b1);
    #(BIT_NS * 2);
    verify("fast2pct");

    // Random bytes, rates and gaps
    for (int n = 0; n < 10; n++) begin
      rb = 8'($urandom);
      f  = real'($urandom_range(980, 1020)) / 1000.0;
      send_frame(rb, f, 1'b1);
      #(BIT_NS * real'($urandom_range(0, 2)) + 1.0);
    end
    #(BIT_NS * 2);
    verify("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
